// File: rtl/seg7_scroll_mux.sv
// rtl/seg7_scroll_mux.sv - multiplexed scrolling 7-segment hex display driver
// Optional anti-ghosting blank cycle per digit period enabled by defining SEG7_BLANK_EN.
module seg7_scroll_mux #(
    parameter int DIGITS      = 4,
    parameter int ADDR_W      = 4,
    parameter int REFRESH_DIV = 16,
    parameter int SCROLL_DIV  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              scroll_en,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic [ADDR_W-1:0] ptr,
    output logic              step
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int SCR_W = $clog2(SCROLL_DIV);

    logic [3:0]        r_msg [DEPTH];
    logic [REF_W-1:0]  r_ref_cnt;
    logic [DIG_W-1:0]  r_dig;
    logic [SCR_W-1:0]  r_scr_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    logic              w_ref_tc;
    logic              w_dig_last;
    logic              w_scr_tc;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [3:0]        w_rd_data;
    logic [DIGITS-1:0] w_an_onecold;
    logic [DIGITS-1:0] w_an_next;

    function automatic logic [6:0] f_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_msg[i] <= 4'h0;
            end
        end else if (wr_en) begin
            r_msg[wr_addr] <= wr_data;
        end
    end

    assign w_ref_tc   = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));
    assign w_dig_last = (r_dig == DIG_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref_cnt <= '0;
            r_dig     <= '0;
        end else begin
            r_ref_cnt <= w_ref_tc ? '0 : r_ref_cnt + 1'b1;
            if (w_ref_tc) begin
                r_dig <= w_dig_last ? '0 : r_dig + 1'b1;
            end
        end
    end

    // Disabling scroll freezes the count so a resume picks up mid-interval.
    assign w_scr_tc = scroll_en && (r_scr_cnt == SCR_W'(SCROLL_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scr_cnt <= '0;
            r_ptr     <= '0;
        end else if (scroll_en) begin
            r_scr_cnt <= w_scr_tc ? '0 : r_scr_cnt + 1'b1;
            if (w_scr_tc) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Leftmost anode shows msg[ptr]; indexing wraps around the buffer.
    assign w_rd_addr = r_ptr + ADDR_W'(r_dig);
    assign w_rd_data = r_msg[w_rd_addr];

    always_comb begin
        w_an_onecold = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_onecold[i] = (i != (DIGITS - 1 - int'(r_dig)));
        end
    end

`ifdef SEG7_BLANK_EN
    logic r_blank;

    // Marks the first output cycle of a fresh digit period for dead time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blank <= 1'b1;
        end else begin
            r_blank <= w_ref_tc;
        end
    end

    assign w_an_next = r_blank ? '1 : w_an_onecold;
`else
    assign w_an_next = w_an_onecold;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= w_an_next;
            r_seg <= f_decode(w_rd_data);
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign ptr  = r_ptr;
    assign step = w_scr_tc;

endmodule

// File: tb/tb_seg7_scroll_mux.sv
// tb/tb_seg7_scroll_mux.sv - directed self-checking bench for seg7_scroll_mux
module tb_seg7_scroll_mux;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       scroll_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] ptr;
    logic       step;

    int n_checks = 0;
    int n_fails  = 0;
    int steps;

    seg7_scroll_mux #(
        .DIGITS      (4),
        .ADDR_W      (4),
        .REFRESH_DIV (4),
        .SCROLL_DIV  (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .scroll_en (scroll_en),
        .an        (an),
        .seg       (seg),
        .ptr       (ptr),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] val, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (an !== val && n < 20);
        check({tag, "_an_found"}, 32'(an), 32'(val));
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 4'h0;
        wr_data   = 4'h0;
        scroll_en = 1'b0;
        #22;
        check("rst_an",   32'(an),   32'(4'b1111));
        check("rst_seg",  32'(seg),  32'(7'b1111111));
        check("rst_ptr",  32'(ptr),  32'(4'h0));
        check("rst_step", 32'(step), 32'(1'b0));
        reset_n = 1'b1;

        tick();
        check("first_an",  32'(an),  32'(4'b0111));
        check("first_seg", 32'(seg), 32'(7'b0000001));
        repeat (4) tick();
        check("refresh_an1", 32'(an), 32'(4'b1011));
        repeat (4) tick();
        check("refresh_an2", 32'(an), 32'(4'b1101));
        repeat (4) tick();
        check("refresh_an3", 32'(an), 32'(4'b1110));
        repeat (4) tick();
        check("refresh_wrap", 32'(an), 32'(4'b0111));
        check("refresh_ptr",  32'(ptr), 32'(4'h0));

        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 4'(i);
            tick();
        end
        wr_en = 1'b0;
        wait_an(4'b0111, "msg_d0"); check("msg_d0_seg", 32'(seg), 32'(7'b0000001));
        wait_an(4'b1011, "msg_d1"); check("msg_d1_seg", 32'(seg), 32'(7'b1001111));
        wait_an(4'b1101, "msg_d2"); check("msg_d2_seg", 32'(seg), 32'(7'b0010010));
        wait_an(4'b1110, "msg_d3"); check("msg_d3_seg", 32'(seg), 32'(7'b0000110));

        scroll_en = 1'b1;
        steps = 0;
        repeat (30) begin
            tick();
            if (step === 1'b1) steps++;
        end
        check("scroll_no_early_step", 32'(steps), 32'd0);
        tick();
        check("scroll_step_tc",  32'(step), 32'(1'b1));
        check("scroll_ptr_hold", 32'(ptr),  32'(4'h0));
        tick();
        check("scroll_step_off", 32'(step), 32'(1'b0));
        check("scroll_ptr_1",    32'(ptr),  32'(4'h1));

        steps = 0;
        repeat (13 * 32) begin
            tick();
            if (step === 1'b1) steps++;
        end
        check("scroll_13_steps", 32'(steps), 32'd13);
        check("scroll_ptr_14",   32'(ptr),   32'(4'hE));
        scroll_en = 1'b0;
        wait_an(4'b0111, "p14_d0"); check("p14_d0_seg", 32'(seg), 32'(7'b0110000));
        wait_an(4'b1011, "p14_d1"); check("p14_d1_seg", 32'(seg), 32'(7'b0111000));
        wait_an(4'b1101, "p14_d2"); check("p14_d2_seg", 32'(seg), 32'(7'b0000001));
        wait_an(4'b1110, "p14_d3"); check("p14_d3_seg", 32'(seg), 32'(7'b1001111));

        scroll_en = 1'b1;
        repeat (10) tick();
        scroll_en = 1'b0;
        steps = 0;
        repeat (50) begin
            tick();
            if (step === 1'b1) steps++;
        end
        check("pause_no_step",  32'(steps), 32'd0);
        check("pause_ptr_hold", 32'(ptr),   32'(4'hE));
        scroll_en = 1'b1;
        steps = 0;
        repeat (20) begin
            tick();
            if (step === 1'b1) steps++;
        end
        check("resume_no_early_step", 32'(steps), 32'd0);
        tick();
        check("resume_step",     32'(step), 32'(1'b1));
        check("resume_ptr_hold", 32'(ptr),  32'(4'hE));
        tick();
        check("resume_ptr_15", 32'(ptr), 32'(4'hF));

        repeat (32) tick();
        check("ptr_wrap_0", 32'(ptr), 32'(4'h0));
        scroll_en = 1'b0;

        wait_an(4'b1110, "wr_pre");
        wait_an(4'b0111, "wr_left");
        wr_en   = 1'b1;
        wr_addr = 4'h0;
        wr_data = 4'h8;
        tick();
        wr_en = 1'b0;
        check("wr_seg_old", 32'(seg), 32'(7'b0000001));
        tick();
        check("wr_seg_new", 32'(seg), 32'(7'b0000000));
        check("wr_an_left", 32'(an),  32'(4'b0111));

        scroll_en = 1'b1;
        repeat (40) tick();
        check("pre_rst_ptr", 32'(ptr), 32'(4'h1));
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_an",   32'(an),   32'(4'b1111));
        check("async_rst_seg",  32'(seg),  32'(7'b1111111));
        check("async_rst_ptr",  32'(ptr),  32'(4'h0));
        check("async_rst_step", 32'(step), 32'(1'b0));
        scroll_en = 1'b0;
        #2;
        reset_n = 1'b1;
        wait_an(4'b0111, "clr_d0"); check("clr_d0_seg", 32'(seg), 32'(7'b0000001));
        wait_an(4'b1110, "clr_d3"); check("clr_d3_seg", 32'(seg), 32'(7'b0000001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
